// File: rtl/mode_switch_pkg.sv
// Shared types and constants for the application-mode arbiter.
// Holds the FSM encoding and the values driven while the display is blanked.
package mode_switch_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_BLANK,
        ST_ARM
    } state_t;

    localparam int MODE_HOME = 0;

    localparam logic [7:0]  BLANK_SEG = 8'hFF;
    localparam logic [3:0]  BLANK_AN  = 4'hF;
    localparam logic [15:0] BLANK_LED = 16'h0;
    localparam int          BLANK_PIX = 0;

endpackage

// File: rtl/mode_switch_controller_filter.sv
// Decodes the mode switches and qualifies a request once it has held still.
// The stability counter saturates at its last value instead of wrapping.
module mode_req_filter
    import mode_switch_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SETTLE_CYCLES = 65536,
    parameter int MW            = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_MODES-2:0] sel,
    input  logic [MW-1:0]        mode,
    input  logic                 start,
    input  logic                 active,
    output logic [MW-1:0]        req,
    output logic [MW-1:0]        pending,
    output logic                 stable_strobe
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Anything other than exactly one raised switch means home.
    always_comb begin
        req = MW'(MODE_HOME);
        if ($onehot(sel)) begin
            for (int i = 0; i < NUM_MODES - 1; i++) begin
                if (sel[i]) req = MW'(i + 1);
            end
        end
    end

    assign stable_strobe = active && (req == pending) && (cnt == CNT_LAST);

    // Track the candidate mode and how long it has stayed unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= MW'(MODE_HOME);
            cnt     <= '0;
        end else if (start) begin
            pending <= req;
            cnt     <= '0;
        end else if (active) begin
            if (req != pending) begin
                if (req != mode) begin
                    pending <= req;
                    cnt     <= '0;
                end
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_switch_controller.sv
// Top-level mode arbiter: commits mode changes on frame boundaries,
// gates buttons to the active mode and muxes the board outputs.
module mode_switch_controller
    import mode_switch_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int NUM_BTN       = 5,
    parameter int PIX_W         = 16,
    parameter int SETTLE_CYCLES = 65536,
    parameter int BLANK_TIMEOUT = 1 << 20
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_MODES-2:0]           sel,
    input  logic [NUM_BTN-1:0]             btn_in,
    input  logic                           frame_begin,
    input  logic [NUM_MODES*PIX_W-1:0]     pix_a_in,
    input  logic [NUM_MODES*PIX_W-1:0]     pix_b_in,
    input  logic [NUM_MODES*8-1:0]         seg_in,
    input  logic [NUM_MODES*4-1:0]         an_in,
    input  logic [NUM_MODES*16-1:0]        led_in,
    output logic [NUM_MODES*NUM_BTN-1:0]   btn_out,
    output logic [PIX_W-1:0]               pix_a,
    output logic [PIX_W-1:0]               pix_b,
    output logic [7:0]                     seg,
    output logic [3:0]                     an,
    output logic [15:0]                    led,
    output logic [$clog2(NUM_MODES)-1:0]   mode,
    output logic                           mode_change
);

    localparam int MW = $clog2(NUM_MODES);
    localparam int TW = $clog2(BLANK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BLANK_TIMEOUT - 1);

    state_t        state, state_n;
    logic [MW-1:0] req, pending;
    logic [TW-1:0] tmo;
    logic          stable_strobe;
    logic          commit;

    mode_req_filter #(
        .NUM_MODES    (NUM_MODES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MW           (MW)
    ) u_filter (
        .clk          (clk),
        .reset_n      (reset_n),
        .sel          (sel),
        .mode         (mode),
        .start        ((state == ST_RUN) && (req != mode)),
        .active       (state == ST_SETTLE),
        .req          (req),
        .pending      (pending),
        .stable_strobe(stable_strobe)
    );

    // Next-state logic; commit marks the cycle the pending mode is taken.
    always_comb begin
        state_n = state;
        commit  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (req != mode) state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (req == mode)        state_n = ST_RUN;
                else if (stable_strobe) state_n = ST_BLANK;
            end
            ST_BLANK: begin
                if (frame_begin || (tmo == TMO_LAST)) begin
                    commit  = 1'b1;
                    state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                if (btn_in == '0) state_n = ST_RUN;
            end
            default: state_n = ST_ARM;
        endcase
    end

    // State, committed mode, commit pulse and saturating blank timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_ARM;
            mode        <= MW'(MODE_HOME);
            mode_change <= 1'b0;
            tmo         <= '0;
        end else begin
            state       <= state_n;
            mode_change <= commit;
            if (commit) mode <= pending;
            if (state != ST_BLANK)  tmo <= '0;
            else if (tmo != TMO_LAST) tmo <= tmo + 1'b1;
        end
    end

    // Zero-latency output mux of the committed mode, blanked while switching.
    always_comb begin
        pix_a   = '0;
        pix_b   = '0;
        seg     = BLANK_SEG;
        an      = BLANK_AN;
        led     = BLANK_LED;
        btn_out = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode == MW'(m)) begin
                pix_a = pix_a_in[m*PIX_W +: PIX_W];
                pix_b = pix_b_in[m*PIX_W +: PIX_W];
                seg   = seg_in[m*8 +: 8];
                an    = an_in[m*4 +: 4];
                led   = led_in[m*16 +: 16];
                if (state == ST_RUN || state == ST_SETTLE)
                    btn_out[m*NUM_BTN +: NUM_BTN] = btn_in;
            end
        end
        if (state == ST_BLANK) begin
            pix_a = PIX_W'(BLANK_PIX);
            pix_b = PIX_W'(BLANK_PIX);
            seg   = BLANK_SEG;
            an    = BLANK_AN;
            led   = BLANK_LED;
        end
    end

endmodule

// File: tb/tb_mode_switch_controller.sv
// Directed bench for the mode arbiter with short settle/timeout values.
// Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
module tb_mode_switch_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  sel;
    logic [4:0]  btn_in;
    logic        frame_begin;
    logic [63:0] pix_a_in, pix_b_in, led_in;
    logic [31:0] seg_in;
    logic [15:0] an_in;
    logic [19:0] btn_out;
    logic [15:0] pix_a, pix_b, led;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  mode;
    logic        mode_change;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mode_switch_controller #(
        .NUM_MODES    (4),
        .NUM_BTN      (5),
        .PIX_W        (16),
        .SETTLE_CYCLES(8),
        .BLANK_TIMEOUT(32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel        (sel),
        .btn_in     (btn_in),
        .frame_begin(frame_begin),
        .pix_a_in   (pix_a_in),
        .pix_b_in   (pix_b_in),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .led_in     (led_in),
        .btn_out    (btn_out),
        .pix_a      (pix_a),
        .pix_b      (pix_b),
        .seg        (seg),
        .an         (an),
        .led        (led),
        .mode       (mode),
        .mode_change(mode_change)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, ".pix_a"}, 64'(pix_a), 64'h0);
        chk({tag, ".pix_b"}, 64'(pix_b), 64'h0);
        chk({tag, ".seg"}, 64'(seg), 64'hFF);
        chk({tag, ".an"}, 64'(an), 64'hF);
        chk({tag, ".led"}, 64'(led), 64'h0);
    endtask

    initial begin
        pix_a_in    = 64'hA333_A222_A111_A000;
        pix_b_in    = 64'hB333_B222_B111_B000;
        seg_in      = 32'hC3C2_C1C0;
        an_in       = 16'h7BDE;
        led_in      = 64'h0008_0004_0002_0001;
        reset_n     = 1'b0;
        sel         = 3'b000;
        btn_in      = 5'b0;
        frame_begin = 1'b0;

        // 1: reset state, home outputs, ARM -> RUN after one edge
        #2;
        chk("rst.mode", 64'(mode), 64'd0);
        chk("rst.mc", 64'(mode_change), 64'd0);
        chk("rst.pix_a", 64'(pix_a), 64'hA000);
        step(2);
        reset_n = 1'b1;
        step(1);
        btn_in = 5'b00001; #1;
        chk("t1.btn_run", 64'(btn_out), 64'h00001);
        btn_in = 5'b0;

        // 3: short request then back home -> no change
        sel = 3'b001;
        step(5);
        chk("t3.noblank", 64'(pix_a), 64'hA000);
        sel = 3'b000;
        step(10);
        chk("t3.mode", 64'(mode), 64'd0);
        chk("t3.mc", 64'(mode_change), 64'd0);
        chk("t3.led", 64'(led), 64'h0001);

        // 2: settle into mode 1, commit on frame_begin
        sel = 3'b001;
        step(8);
        chk("t2.presettle", 64'(pix_a), 64'hA000);
        step(1);
        chk_blank("t2.blank");
        step(3);
        frame_begin = 1'b1; #1;
        chk("t2.blank_fb", 64'(pix_b), 64'h0);
        chk("t2.mode_pre", 64'(mode), 64'd0);
        step(1);
        frame_begin = 1'b0;
        chk("t2.mode", 64'(mode), 64'd1);
        chk("t2.mc", 64'(mode_change), 64'd1);
        chk("t2.pix_b", 64'(pix_b), 64'hB111);
        step(1);
        chk("t2.mc_off", 64'(mode_change), 64'd0);

        // 4: button held across commit into mode 2
        btn_in = 5'b00001;
        sel = 3'b010; #1;
        chk("t4.btn_m1", 64'(btn_out), 64'h00020);
        step(9);
        chk("t4.btn_blank", 64'(btn_out), 64'h0);
        frame_begin = 1'b1;
        step(1);
        frame_begin = 1'b0;
        chk("t4.mode", 64'(mode), 64'd2);
        chk("t4.btn_arm", 64'(btn_out), 64'h0);
        step(3);
        chk("t4.btn_held", 64'(btn_out), 64'h0);
        btn_in = 5'b0;
        step(1);
        btn_in = 5'b00001; #1;
        chk("t4.btn_m2", 64'(btn_out), 64'h00400);
        btn_in = 5'b0;

        // 5: non-one-hot selection means home
        sel = 3'b011;
        step(9);
        chk("t5.blank_an", 64'(an), 64'hF);
        frame_begin = 1'b1;
        step(1);
        frame_begin = 1'b0;
        chk("t5.mode", 64'(mode), 64'd0);
        chk("t5.mc", 64'(mode_change), 64'd1);
        chk("t5.seg", 64'(seg), 64'hC0);
        step(1);

        // 6: forced commit after 32 BLANK cycles
        sel = 3'b100;
        step(9);
        chk_blank("t6.blank0");
        step(31);
        chk("t6.blank31", 64'(pix_a), 64'h0);
        chk("t6.mode_pre", 64'(mode), 64'd0);
        step(1);
        chk("t6.mode", 64'(mode), 64'd3);
        chk("t6.mc", 64'(mode_change), 64'd1);
        chk("t6.pix_a", 64'(pix_a), 64'hA333);
        chk("t6.an", 64'(an), 64'h7);
        step(1);

        // 6b: reset in the middle of BLANK
        sel = 3'b001;
        step(9);
        step(5);
        chk("t6b.blank", 64'(led), 64'h0);
        reset_n = 1'b0; #1;
        chk("t6b.mode", 64'(mode), 64'd0);
        chk("t6b.pix_a", 64'(pix_a), 64'hA000);
        chk("t6b.mc", 64'(mode_change), 64'd0);
        chk("t6b.btn", 64'(btn_out), 64'h0);
        sel = 3'b000;
        step(1);
        reset_n = 1'b1;
        step(2);
        chk("t6b.after", 64'(seg), 64'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
